// File: rtl/pe_job_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : pe_job_scheduler
// Brief    : Round-robin owner of the shared PE fetch/execute pipeline; launches
//            one job, tracks it until idle, drains stage 2 and pulses done.
//            Optional macro WATCHDOG_EN adds a run watchdog (pe_abort / err).
// Revision : 1.0 - initial release
// =============================================================================
module pe_job_scheduler #(
    parameter int N_REQ        = 4,
    parameter int PC_LEN       = 12,
    parameter int DRAIN_CYCLES = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*PC_LEN-1:0] req_pc,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    pe_valid,
    output logic [PC_LEN-1:0]       pe_start_pc,
    input  logic                    pe_busy,
    output logic                    pe_abort,
    output logic                    sched_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DR_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   arb_win, next_ptr;
    logic               arb_found;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               pe_valid_q, pe_valid_d;
    logic [PC_LEN-1:0]  pc_q, pc_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic [PC_LEN-1:0]  pc_arr [N_REQ];
    logic               wd_fire;

    for (genvar g = 0; g < N_REQ; g++) begin : g_pc_slice
        assign pc_arr[g] = req_pc[g*PC_LEN +: PC_LEN];
    end

    // First set request scanning upward from rr_ptr, wrapping at N_REQ.
    always_comb begin : p_arb
        int idx;
        arb_found = 1'b0;
        arb_win   = rr_ptr_q;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!arb_found && req[idx[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = idx[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        grant_d    = grant_q;
        done_d     = '0;
        pe_valid_d = 1'b0;
        pc_d       = pc_q;
        drain_d    = drain_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    win_d          = arb_win;
                    grant_d        = '0;
                    grant_d[arb_win] = 1'b1;
                    pc_d           = pc_arr[arb_win];
                    pe_valid_d     = 1'b1;
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (wd_fire) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (pe_busy) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!pe_busy) begin
                    drain_d = DR_W'(DRAIN_CYCLES - 1);
                    state_d = S_DRAIN;
                end else if (wd_fire) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    done_d   = grant_q;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            pe_valid_q <= 1'b0;
            pc_q       <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            pe_valid_q <= pe_valid_d;
            pc_q       <= pc_d;
            drain_q    <= drain_d;
        end
    end

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0]  wd_q, wd_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic             abort_q, abort_d;

    // Fires on the edge where the count reaches TIMEOUT-1; a falling pe_busy in RUN wins.
    assign wd_fire = ((state_q == S_WAIT_BUSY) || (state_q == S_RUN && pe_busy))
                     && (wd_q == WD_W'(TIMEOUT - 2));

    always_comb begin
        wd_d    = wd_q;
        err_d   = '0;
        abort_d = 1'b0;
        if (state_q == S_IDLE) begin
            wd_d = '0;
        end else if (state_q == S_WAIT_BUSY || state_q == S_RUN) begin
            wd_d = wd_q + 1'b1;
        end
        if (wd_fire) begin
            err_d   = grant_q;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_q    <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign err      = err_q;
    assign pe_abort = abort_q;
`else
    assign wd_fire  = 1'b0;
    assign err      = '0;
    assign pe_abort = 1'b0;
`endif

    assign grant       = grant_q;
    assign done        = done_q;
    assign pe_valid    = pe_valid_q;
    assign pe_start_pc = pc_q;
    assign sched_busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pe_job_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_pe_job_scheduler
// Brief    : Scoreboard bench for pe_job_scheduler (launch/done queues).
// Revision : 1.0 - initial release
// =============================================================================
module tb_pe_job_scheduler;

    localparam int N_REQ        = 4;
    localparam int PC_LEN       = 12;
    localparam int DRAIN_CYCLES = 4;
`ifdef WATCHDOG_EN
    localparam int TIMEOUT      = 16;
`else
    localparam int TIMEOUT      = 1024;
`endif

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*PC_LEN-1:0] req_pc = '0;
    logic                    pe_busy = 1'b0;
    logic [N_REQ-1:0]        grant, done, err;
    logic                    pe_valid, pe_abort, sched_busy;
    logic [PC_LEN-1:0]       pe_start_pc;

    typedef struct packed {
        logic [N_REQ-1:0]  grant;
        logic [PC_LEN-1:0] pc;
    } launch_t;

    launch_t          launch_q[$];
    logic [N_REQ-1:0] done_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    pe_job_scheduler #(
        .N_REQ(N_REQ), .PC_LEN(PC_LEN), .DRAIN_CYCLES(DRAIN_CYCLES), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rstn(rstn), .req(req), .req_pc(req_pc),
        .grant(grant), .done(done), .err(err),
        .pe_valid(pe_valid), .pe_start_pc(pe_start_pc), .pe_busy(pe_busy),
        .pe_abort(pe_abort), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_pc(input int i, input logic [PC_LEN-1:0] pc);
        req_pc[i*PC_LEN +: PC_LEN] = pc;
    endtask

    task automatic expect_job(input logic [N_REQ-1:0] g, input logic [PC_LEN-1:0] pc);
        launch_q.push_back('{grant: g, pc: pc});
        done_q.push_back(g);
    endtask

    // One full job: launch check, PE busy for busy_len cycles, drain, done pulse.
    task automatic job(input int busy_len, input int exp_lat,
                       input logic [N_REQ-1:0] drop_mid, input logic [N_REQ-1:0] drop_done);
        int                      t;
        launch_t                 e;
        logic [N_REQ-1:0]        ed;
        logic [N_REQ*PC_LEN-1:0] saved_pc;
        t = 0;
        while (!pe_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!pe_valid) begin
            check("launch_seen", 0, 1);
            return;
        end
        if (launch_q.size() == 0 || done_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e  = launch_q.pop_front();
        ed = done_q.pop_front();
        check("launch_lat", t, exp_lat);
        check("grant", grant, e.grant);
        check("start_pc", pe_start_pc, e.pc);
        @(negedge clk);
        check("valid_pulse", pe_valid, 0);
        @(negedge clk);
        pe_busy  = 1'b1;
        saved_pc = req_pc;
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            if (i == 0) req_pc = ~saved_pc;
            if (i == 1) req = req & ~drop_mid;
            check("hold_grant", grant, e.grant);
            check("pc_stable", pe_start_pc, e.pc);
            check("no_strobe", {err, pe_abort, pe_valid}, '0);
        end
        req_pc  = saved_pc;
        pe_busy = 1'b0;
        // done registers on the 4th edge after the edge that samples pe_busy low
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            @(negedge clk);
            check("drain_no_done", done, '0);
        end
        @(negedge clk);
        check("done", done, ed);
        check("grant_clr", grant, '0);
        check("idle_gap", sched_busy, 0);
        req = req & ~drop_done;
        @(negedge clk);
        check("done_pulse", done, '0);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            check("grant_onehot", $countones(grant) <= 1, 1);
            check("pulse_excl", $countones({|done, |err, pe_abort}) <= 1, 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int      t;
        launch_t e;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_grant", grant, '0);
        check("rst_out", {done, err, pe_valid, pe_abort, sched_busy}, '0);
        check("rst_pc", pe_start_pc, '0);
        rstn = 1'b1;
        @(negedge clk);

        // pe_busy glitch in IDLE
        pe_busy = 1'b1;
        @(negedge clk);
        check("glitch_idle", {sched_busy, grant}, '0);
        pe_busy = 1'b0;
        @(negedge clk);

        // T2 fairness, all requesters held
        for (int i = 0; i < N_REQ; i++) set_pc(i, PC_LEN'(12'h100 + 12'h11 * i));
        expect_job(4'b0001, 12'h100);
        expect_job(4'b0010, 12'h111);
        expect_job(4'b0100, 12'h122);
        expect_job(4'b1000, 12'h133);
        expect_job(4'b0001, 12'h100);
        req = 4'b1111;
        job(3, 1, '0, '0);
        job(3, 0, '0, '0);
        job(3, 0, '0, '0);
        job(3, 0, '0, '0);
        job(3, 0, '0, 4'b1111);
        @(negedge clk);
        check("t2_quiet", {grant, sched_busy}, '0);

        // T1 single job
        set_pc(1, 12'h020);
        expect_job(4'b0010, 12'h020);
        req = 4'b0010;
        job(6, 1, '0, 4'b0010);
        @(negedge clk);
        check("t1_quiet", {grant, sched_busy}, '0);

        // T3 owner withdraws mid-run; next grant wraps to bit 0
        set_pc(0, 12'h0A0);
        set_pc(2, 12'h2B2);
        expect_job(4'b0100, 12'h2B2);
        expect_job(4'b0001, 12'h0A0);
        req = 4'b0101;
        job(3, 1, 4'b0100, '0);
        job(3, 0, '0, 4'b0001);
        @(negedge clk);

        // T4 async reset during RUN
        set_pc(2, 12'h0A2);
        set_pc(3, 12'h3D3);
        launch_q.push_back('{grant: 4'b0100, pc: 12'h0A2});
        req = 4'b0100;
        t = 0;
        while (!pe_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t4_launch", pe_valid, 1);
        e = launch_q.pop_front();
        check("t4_grant", grant, e.grant);
        check("t4_pc", pe_start_pc, e.pc);
        repeat (2) @(negedge clk);
        pe_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_in_run", sched_busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("t4_rst_grant", grant, '0);
        check("t4_rst_out", {pe_valid, done, sched_busy}, '0);
        pe_busy = 1'b0;
        req     = 4'b1001;
        repeat (2) @(negedge clk);
        check("t4_no_done", done, '0);
        rstn = 1'b1;
        expect_job(4'b0001, 12'h0A0);
        job(3, 1, '0, 4'b1001);
        @(negedge clk);

`ifdef WATCHDOG_EN
        // T5 watchdog abort with pe_busy stuck high
        set_pc(1, 12'h3C3);
        launch_q.push_back('{grant: 4'b0010, pc: 12'h3C3});
        req = 4'b0010;
        t = 0;
        while (!pe_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_launch", pe_valid, 1);
        e = launch_q.pop_front();
        check("t5_grant", grant, e.grant);
        repeat (2) @(negedge clk);
        pe_busy = 1'b1;
        repeat (13) @(negedge clk);
        check("t5_early", {err, pe_abort}, '0);
        @(negedge clk);
        check("t5_abort", pe_abort, 1);
        check("t5_err", err, 4'b0010);
        check("t5_grant_clr", {grant, done}, '0);
        pe_busy = 1'b0;
        req     = 4'b0001;
        expect_job(4'b0001, 12'h0A0);
        @(negedge clk);
        check("t5_pulse", {err, pe_abort}, '0);
        job(3, 0, '0, 4'b0001);
`else
        // T5 without watchdog: stuck pe_busy keeps grant, no abort/err
        expect_job(4'b0010, 12'h020);
        set_pc(1, 12'h020);
        req = 4'b0010;
        job(100, 1, '0, 4'b0010);
`endif
        @(negedge clk);
        check("final_quiet", {grant, sched_busy}, '0);
        check("sb_drained", launch_q.size() + done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
